// File: rtl/keypad_pkg.sv
// Shared constants for the keypad conditioning slice.
// NUM_KEYS_DEFAULT : number of keypad lines on the board (0-9, '*', '#')
// KEY_*            : key indices as they appear on key_code
// KEY_CODE_W       : width of the encoded key index
package keypad_pkg;

  localparam int NUM_KEYS_DEFAULT = 12;
  localparam int KEY_CODE_W       = 4;

  localparam logic [KEY_CODE_W-1:0] KEY_0    = 4'd0;
  localparam logic [KEY_CODE_W-1:0] KEY_1    = 4'd1;
  localparam logic [KEY_CODE_W-1:0] KEY_2    = 4'd2;
  localparam logic [KEY_CODE_W-1:0] KEY_3    = 4'd3;
  localparam logic [KEY_CODE_W-1:0] KEY_4    = 4'd4;
  localparam logic [KEY_CODE_W-1:0] KEY_5    = 4'd5;
  localparam logic [KEY_CODE_W-1:0] KEY_6    = 4'd6;
  localparam logic [KEY_CODE_W-1:0] KEY_7    = 4'd7;
  localparam logic [KEY_CODE_W-1:0] KEY_8    = 4'd8;
  localparam logic [KEY_CODE_W-1:0] KEY_9    = 4'd9;
  localparam logic [KEY_CODE_W-1:0] KEY_STAR = 4'd10;
  localparam logic [KEY_CODE_W-1:0] KEY_HASH = 4'd11;

endpackage

// File: rtl/key_debounce_ch.sv
// One keypad channel: synchroniser, stability counter, debounced level and
// press (rising-edge) pulse.
// Ports:
//   clk   : system clock, all state on posedge
//   rst   : asynchronous active-high reset
//   raw   : raw key line, 1 = pressed, asynchronous, may bounce
//   level : debounced key state
//   press : 1-cycle pulse in the cycle level rises
module key_debounce_ch
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  // cnt counts consecutive cycles where the synchronised input disagrees
  // with the accepted level; any agreeing cycle restarts it, so a bounce
  // back to the stable value throws away the partial count. Accepting a
  // change clears it, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      press  <= 1'b0;
      if (sync != level) begin
        if (cnt == LAST) begin
          level <= sync;
          cnt   <= '0;
          // Only presses pulse; releases just drop level.
          press <= sync;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/keypad_debounce.sv
// Keypad conditioning: per-key debounce channels plus a single-press encoder.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   key_raw   : raw keypad lines, 1 = pressed
//   key_level : debounced key states
//   key_pulse : 1-cycle pulse per debounced press
//   key_valid : 1-cycle, exactly one key_pulse bit set
//   key_code  : pressed key index (lowest index when several pulse)
//   key_multi : 1-cycle, two or more key_pulse bits set
//   any_held  : OR of key_level
//
// Output contract: key_pulse, key_valid and key_multi are single-cycle
// strobes synchronous to clk with no ready/back-pressure; a consumer must
// sample them on the edge following their assertion or lose them. key_code
// is only meaningful while key_valid is high.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS        = NUM_KEYS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_KEYS-1:0]   key_raw,
  output logic [NUM_KEYS-1:0]   key_level,
  output logic [NUM_KEYS-1:0]   key_pulse,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_multi,
  output logic                  any_held
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (key_raw[i]),
      .level (key_level[i]),
      .press (key_pulse[i])
    );
  end

  // Saturating popcount (0, 1, 2 = "two or more") and lowest set index.
  logic [1:0]            pulse_cnt;
  logic [KEY_CODE_W-1:0] low_idx;

  always_comb begin
    pulse_cnt = 2'd0;
    low_idx   = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_pulse[i]) begin
        pulse_cnt = (pulse_cnt == 2'd2) ? 2'd2 : pulse_cnt + 2'd1;
        low_idx   = KEY_CODE_W'(i);
      end
    end
  end

  // key_pulse is already a flop output in each channel, so decoding it here
  // keeps the encoder outputs in the same cycle as the pulse while remaining
  // driven only by registers (no path from key_raw). code_q remembers the
  // last code for the idle cycles.
  logic [KEY_CODE_W-1:0] code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
    end else if (|key_pulse) begin
      code_q <= low_idx;
    end
  end

  assign key_valid = (pulse_cnt == 2'd1);
  assign key_multi = (pulse_cnt == 2'd2);
  assign key_code  = (|key_pulse) ? low_idx : code_q;
  assign any_held  = |key_level;

endmodule

// File: tb/tb_keypad_debounce.sv
module tb_keypad_debounce;
  import keypad_pkg::*;

  localparam int NK = 12;
  localparam int DB = 8;
  localparam int SS = 2;
  // Scoreboard entry: {edge[15:0], code[3:0], multi, valid, pulse[NK-1:0]}
  localparam int EW = 16 + 4 + 1 + 1 + NK;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- DUTs ----------------
  logic [NK-1:0] key_raw = '0;
  logic [NK-1:0] key_level, key_pulse;
  logic          key_valid, key_multi, any_held;
  logic [3:0]    key_code;

  keypad_debounce #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .key_level (key_level),
    .key_pulse (key_pulse),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_multi (key_multi),
    .any_held  (any_held)
  );

  // Single-key instance with the shortest debounce.
  logic [0:0] b_raw = '0;
  logic [0:0] b_level, b_pulse;
  logic       b_valid, b_multi, b_held;
  logic [3:0] b_code;

  keypad_debounce #(.NUM_KEYS(1), .DEBOUNCE_CYCLES(1), .SYNC_STAGES(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (b_raw),
    .key_level (b_level),
    .key_pulse (b_pulse),
    .key_valid (b_valid),
    .key_code  (b_code),
    .key_multi (b_multi),
    .any_held  (b_held)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [NK-1:0] pulse, input logic valid, input logic multi,
                          input logic [3:0] code, input int at_edge);
    exp_q.push_back({16'(at_edge), code, multi, valid, pulse});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, 32'(key_level), 32'd0);
    check({tag, "_pulse"}, 32'(key_pulse), 32'd0);
    check({tag, "_valid"}, 32'(key_valid), 32'd0);
    check({tag, "_code"},  32'(key_code),  32'd0);
    check({tag, "_multi"}, 32'(key_multi), 32'd0);
    check({tag, "_held"},  32'(any_held),  32'd0);
  endtask

  // Scoreboard: every cycle with encoder activity must match the next
  // expected event, including the edge it lands on.
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (key_pulse != '0 || key_valid || key_multi) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(key_pulse), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ev_pulse", 32'(key_pulse), 32'(e[NK-1:0]));
        check("ev_valid", 32'(key_valid), 32'(e[NK]));
        check("ev_multi", 32'(key_multi), 32'(e[NK+1]));
        check("ev_code",  32'(key_code),  32'(e[NK+5:NK+2]));
        check("ev_edge",  32'(edge_cnt),  32'(e[EW-1:NK+6]));
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : stim
    int e;

    // Reset values
    step(3);
    check_all_zero("rst_init");
    rst = 1'b0;

    // Clean press on key 1: visible 10 edges after the drive edge
    step(2);
    e = edge_cnt;
    key_raw[1] = 1'b1;
    push_exp(12'h002, 1'b1, 1'b0, KEY_1, e + 10);
    step(9);
    check("press_level_early", 32'(key_level[1]), 32'd0);
    step(1);
    check("press_level", 32'(key_level[1]), 32'd1);
    check("press_held",  32'(any_held), 32'd1);
    step(20);
    key_raw[1] = 1'b0;
    step(15);
    check("release_level", 32'(key_level[1]), 32'd0);
    check("release_held",  32'(any_held), 32'd0);

    // 7-cycle glitch on key 3 is rejected
    key_raw[3] = 1'b1;
    step(7);
    key_raw[3] = 1'b0;
    step(15);
    check("glitch_level", 32'(key_level[3]), 32'd0);

    // Bounce 1,0,1,1,0 then settle high
    key_raw[3] = 1'b1; step(1);
    key_raw[3] = 1'b0; step(1);
    key_raw[3] = 1'b1; step(2);
    key_raw[3] = 1'b0; step(1);
    e = edge_cnt;
    key_raw[3] = 1'b1;
    push_exp(12'h008, 1'b1, 1'b0, KEY_3, e + 10);
    step(9);
    check("bounce_level_early", 32'(key_level[3]), 32'd0);
    step(1);
    check("bounce_level", 32'(key_level[3]), 32'd1);
    step(20);
    key_raw[3] = 1'b0;
    step(15);

    // Simultaneous press on keys 0 and 2
    e = edge_cnt;
    key_raw[0] = 1'b1;
    key_raw[2] = 1'b1;
    push_exp(12'h005, 1'b0, 1'b1, KEY_0, e + 10);
    step(10);
    check("multi_level", 32'(key_level), 32'h005);
    step(5);
    key_raw[0] = 1'b0;
    key_raw[2] = 1'b0;
    step(15);

    // Staggered: '#' held, key 5 pressed 20 cycles later
    e = edge_cnt;
    key_raw[11] = 1'b1;
    push_exp(12'h800, 1'b1, 1'b0, KEY_HASH, e + 10);
    step(10);
    for (int i = 0; i < 10; i++) begin
      check("stag_held_a", 32'(any_held), 32'd1);
      step(1);
    end
    check("stag_code_hold", 32'(key_code), 32'd11);
    key_raw[5] = 1'b1;
    push_exp(12'h020, 1'b1, 1'b0, KEY_5, e + 30);
    for (int i = 0; i < 15; i++) begin
      step(1);
      check("stag_held_b", 32'(any_held), 32'd1);
    end
    check("stag_code_last", 32'(key_code), 32'd5);
    check("stag_level", 32'(key_level), 32'h820);
    key_raw[11] = 1'b0;
    key_raw[5]  = 1'b0;
    step(15);

    // Reset mid-run and mid-debounce
    e = edge_cnt;
    key_raw[9] = 1'b1;
    push_exp(12'h200, 1'b1, 1'b0, KEY_9, e + 10);
    step(12);
    check("pre_rst_level", 32'(key_level), 32'h200);
    key_raw[2] = 1'b1;
    step(7);
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    key_raw[9] = 1'b0;
    step(3);
    rst = 1'b0;
    e = edge_cnt;
    push_exp(12'h004, 1'b1, 1'b0, KEY_2, e + 10);
    step(9);
    check("rst_level_early", 32'(key_level[2]), 32'd0);
    step(1);
    check("rst_level", 32'(key_level[2]), 32'd1);
    step(5);
    key_raw[2] = 1'b0;
    step(15);

    // DEBOUNCE_CYCLES=1 instance: accepted after one mismatch cycle
    b_raw = 1'b1;
    step(2);
    check("d1_level_early", 32'(b_level), 32'd0);
    step(1);
    check("d1_level", 32'(b_level), 32'd1);
    check("d1_pulse", 32'(b_pulse), 32'd1);
    check("d1_valid", 32'(b_valid), 32'd1);
    check("d1_code",  32'(b_code),  32'd0);
    step(1);
    check("d1_pulse_once", 32'(b_pulse), 32'd0);

    step(20);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
